// File: rtl/dual_buf_pkg.sv
// -----------------------------------------------------------------------------
// dual_buf_pkg
// Shared types and constants for the multi-channel ping-pong ADC capture block:
//   - capture FSM state encoding
//   - trigger mode encoding (CTRL[1:0])
//   - register addresses on the MCU bus
//   - value returned for unmapped reads (also the bus read-data reset value)
// -----------------------------------------------------------------------------
package dual_buf_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SAMPLING   = 2'd1,
        SWITCH_BUF = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TRIG_RISE   = 2'd0,
        TRIG_FALL   = 2'd1,
        TRIG_EITHER = 2'd2,
        TRIG_FREE   = 2'd3
    } trig_mode_t;

    localparam logic [15:0] ADDR_STATUS   = 16'h4000;
    localparam logic [15:0] ADDR_CTRL     = 16'h4001;
    localparam logic [15:0] ADDR_DECIM    = 16'h4002;
    localparam logic [15:0] RD_IDLE_VALUE = 16'hFFFF;

    // Free-run mode treats every cycle as a trigger.
    function automatic logic trig_fires(input trig_mode_t mode,
                                        input logic       rise,
                                        input logic       fall);
        case (mode)
            TRIG_RISE:   return rise;
            TRIG_FALL:   return fall;
            TRIG_EITHER: return rise | fall;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dual_buf_ram.sv
// -----------------------------------------------------------------------------
// dual_buf_ram
// Simple dual-port block RAM: one synchronous write port, one read port with a
// registered output (one cycle read latency). Contents are never reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every cycle
//   rd_data  - registered read data
// -----------------------------------------------------------------------------
module dual_buf_ram #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 2048,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/multi_ch_dual_buffer.sv
// -----------------------------------------------------------------------------
// multi_ch_dual_buffer
// Captures CHANNELS synchronised ADC streams into per-channel ping-pong
// buffers on a selectable trigger, and exposes buffers plus STATUS/CTRL
// (and optionally DECIM) registers to the MCU bus bridge.
// Optional feature macro: DUAL_BUF_DECIM_EN (adds the DECIM register and the
// decimation counter; without it every adc_clk rise is stored).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - bus access enable, qualifies addr_en/rd_en/wr_en
//   addr_en         - latch rd_data as register/buffer address
//   rd_en           - MCU write strobe, data on rd_data
//   wr_en           - MCU read strobe, result on wr_data one clk later
//   adc_clk         - sample strobe, sampled on its rising edge
//   sync_adc_data   - channel k at [k*ADC_WIDTH +: ADC_WIDTH]
//   stable          - capture permitted
//   sync_signal_in  - trigger source
//   rd_data         - bus write data / address
//   wr_data         - bus read data
//   frame_ready     - a completed frame is available in the read half
// -----------------------------------------------------------------------------
module multi_ch_dual_buffer
    import dual_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADC_WIDTH  = 12,
    parameter int CHANNELS   = 2,
    parameter int BUF_SIZE   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          addr_en,
    input  logic                          rd_en,
    input  logic                          wr_en,
    input  logic                          adc_clk,
    input  logic [CHANNELS*ADC_WIDTH-1:0] sync_adc_data,
    input  logic                          stable,
    input  logic                          sync_signal_in,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          frame_ready
);

    localparam int          PTR_W     = $clog2(BUF_SIZE);
    localparam int          RAM_AW    = PTR_W + 1;
    localparam int          CH_W      = DATA_WIDTH - PTR_W;
    localparam int unsigned BUF_WORDS = CHANNELS * BUF_SIZE;

    state_t                 state_q, state_d;
    logic                   write_buf_q, write_buf_d;
    logic [PTR_W-1:0]       write_ptr_q, write_ptr_d;
    logic                   has_switched_q, has_switched_d;
    logic                   overflow_q, overflow_d;
    logic                   reg_read_q, reg_read_d;
    trig_mode_t             trig_mode_q, trig_mode_d;
    trig_mode_t             frame_mode_q, frame_mode_d;
    logic [DATA_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   sig_q, sig_d;
    logic                   sig_prev_q, sig_prev_d;
    logic                   adc_prev_q, adc_prev_d;
`ifdef DUAL_BUF_DECIM_EN
    logic [7:0]             decim_q, decim_d;
    logic [7:0]             decim_frame_q, decim_frame_d;
    logic [7:0]             decim_cnt_q, decim_cnt_d;
`endif

    logic                   sig_rise, sig_fall, adc_rise;
    logic                   fire_idle, fire_frame;
    logic                   sample_take;
    logic                   ram_we;
    logic [RAM_AW-1:0]      ram_wr_addr, ram_rd_addr;
    logic [ADC_WIDTH-1:0]   ram_rd_data [CHANNELS];
    logic [ADC_WIDTH-1:0]   sel_sample;
    logic [DATA_WIDTH-1:0]  rd_value;

    // Trigger edges come from a registered copy of the comparator, so they are
    // qualified one clk after the input edge.
    assign sig_rise   = sig_q & ~sig_prev_q;
    assign sig_fall   = ~sig_q & sig_prev_q;
    assign adc_rise   = adc_clk & ~adc_prev_q;
    // IDLE arms on the live CTRL value; overflow detection in SWITCH_BUF uses
    // the mode latched for the frame in flight.
    assign fire_idle  = trig_fires(trig_mode_q, sig_rise, sig_fall);
    assign fire_frame = trig_fires(frame_mode_q, sig_rise, sig_fall);

    assign ram_wr_addr = {write_buf_q, write_ptr_q};
    // The MCU always sees the half that is not being filled.
    assign ram_rd_addr = {~write_buf_q, addr_q[PTR_W-1:0]};

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            dual_buf_ram #(
                .WIDTH (ADC_WIDTH),
                .DEPTH (2 * BUF_SIZE)
            ) u_ram (
                .clk     (clk),
                .wr_en   (ram_we),
                .wr_addr (ram_wr_addr),
                .wr_data (sync_adc_data[gi*ADC_WIDTH +: ADC_WIDTH]),
                .rd_addr (ram_rd_addr),
                .rd_data (ram_rd_data[gi])
            );
        end
    endgenerate

    // Channel select from the upper address bits.
    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (addr_q[DATA_WIDTH-1:PTR_W] == CH_W'(k)) begin
                sel_sample = ram_rd_data[k];
            end
        end
    end

    always_comb begin
        rd_value = DATA_WIDTH'(RD_IDLE_VALUE);
        if (32'(addr_q) < BUF_WORDS) begin
            rd_value = DATA_WIDTH'(sel_sample);
        end else if (addr_q == DATA_WIDTH'(ADDR_STATUS)) begin
            rd_value = {{(DATA_WIDTH-2){1'b0}}, overflow_q, has_switched_q};
        end else if (addr_q == DATA_WIDTH'(ADDR_CTRL)) begin
            rd_value = {{(DATA_WIDTH-2){1'b0}}, trig_mode_q};
        end
`ifdef DUAL_BUF_DECIM_EN
        else if (addr_q == DATA_WIDTH'(ADDR_DECIM)) begin
            rd_value = {{(DATA_WIDTH-8){1'b0}}, decim_q};
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        write_buf_d    = write_buf_q;
        write_ptr_d    = write_ptr_q;
        has_switched_d = has_switched_q;
        overflow_d     = overflow_q;
        reg_read_d     = reg_read_q;
        trig_mode_d    = trig_mode_q;
        frame_mode_d   = frame_mode_q;
        addr_d         = addr_q;
        wr_data_d      = wr_data_q;
        sig_d          = sync_signal_in;
        sig_prev_d     = sig_q;
        adc_prev_d     = adc_clk;
        ram_we         = 1'b0;
`ifdef DUAL_BUF_DECIM_EN
        decim_d        = decim_q;
        decim_frame_d  = decim_frame_q;
        decim_cnt_d    = decim_cnt_q;
        sample_take    = adc_rise && (decim_cnt_q == 8'd0);
`else
        sample_take    = adc_rise;
`endif

        if (en && addr_en) begin
            addr_d = rd_data;
        end

        // Register writes; a clear of overflow may be overridden below by a
        // trigger in the same cycle, keeping the flag sticky.
        if (en && rd_en) begin
            if (addr_q == DATA_WIDTH'(ADDR_STATUS)) begin
                reg_read_d = rd_data[0];
                if (rd_data[1]) begin
                    overflow_d = 1'b0;
                end
            end
            if (addr_q == DATA_WIDTH'(ADDR_CTRL)) begin
                trig_mode_d = trig_mode_t'(rd_data[1:0]);
            end
`ifdef DUAL_BUF_DECIM_EN
            if (addr_q == DATA_WIDTH'(ADDR_DECIM)) begin
                decim_d = rd_data[7:0];
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (fire_idle && reg_read_q) begin
                    overflow_d = 1'b1;
                end else if (fire_idle && stable) begin
                    state_d      = SAMPLING;
                    write_ptr_d  = '0;
                    frame_mode_d = trig_mode_q;
`ifdef DUAL_BUF_DECIM_EN
                    decim_frame_d = decim_q;
                    decim_cnt_d   = 8'd0;
`endif
                end
            end
            SAMPLING: begin
                if (!stable) begin
                    // Partial half is abandoned; write_buf stays put.
                    state_d = IDLE;
                end else begin
`ifdef DUAL_BUF_DECIM_EN
                    if (adc_rise) begin
                        decim_cnt_d = (decim_cnt_q == decim_frame_q) ? 8'd0
                                                                     : decim_cnt_q + 8'd1;
                    end
`endif
                    if (sample_take) begin
                        ram_we = 1'b1;
                        if (write_ptr_q == PTR_W'(BUF_SIZE - 1)) begin
                            state_d = SWITCH_BUF;
                        end else begin
                            write_ptr_d = write_ptr_q + PTR_W'(1);
                        end
                    end
                end
            end
            SWITCH_BUF: begin
                if (fire_frame) begin
                    overflow_d = 1'b1;
                end
                if (!reg_read_q) begin
                    write_buf_d    = ~write_buf_q;
                    has_switched_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // MCU acknowledging a frame wins over a swap in the same cycle.
        if (reg_read_d && !reg_read_q) begin
            has_switched_d = 1'b0;
        end

        if (en && wr_en) begin
            wr_data_d = rd_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            write_buf_q    <= 1'b0;
            write_ptr_q    <= '0;
            has_switched_q <= 1'b0;
            overflow_q     <= 1'b0;
            reg_read_q     <= 1'b0;
            trig_mode_q    <= TRIG_RISE;
            frame_mode_q   <= TRIG_RISE;
            addr_q         <= '0;
            wr_data_q      <= DATA_WIDTH'(RD_IDLE_VALUE);
            sig_q          <= 1'b0;
            sig_prev_q     <= 1'b0;
            adc_prev_q     <= 1'b0;
`ifdef DUAL_BUF_DECIM_EN
            decim_q        <= 8'd0;
            decim_frame_q  <= 8'd0;
            decim_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            write_buf_q    <= write_buf_d;
            write_ptr_q    <= write_ptr_d;
            has_switched_q <= has_switched_d;
            overflow_q     <= overflow_d;
            reg_read_q     <= reg_read_d;
            trig_mode_q    <= trig_mode_d;
            frame_mode_q   <= frame_mode_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            sig_q          <= sig_d;
            sig_prev_q     <= sig_prev_d;
            adc_prev_q     <= adc_prev_d;
`ifdef DUAL_BUF_DECIM_EN
            decim_q        <= decim_d;
            decim_frame_q  <= decim_frame_d;
            decim_cnt_q    <= decim_cnt_d;
`endif
        end
    end

    assign wr_data     = wr_data_q;
    assign frame_ready = has_switched_q;

endmodule

// File: tb/tb_multi_ch_dual_buffer.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_dual_buffer
// Scenario bench for multi_ch_dual_buffer with a reference model that tracks
// which half each captured frame lands in and what the MCU should read back.
// -----------------------------------------------------------------------------
module tb_multi_ch_dual_buffer;

    localparam int DW = 16;
    localparam int AWD = 12;
    localparam int CH = 2;
    localparam int BS = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0, addr_en = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic              adc_clk = 1'b0;
    logic [CH*AWD-1:0] sync_adc_data = '0;
    logic              stable = 1'b1;
    logic              sync_signal_in = 1'b0;
    logic [DW-1:0]     rd_data = '0;
    logic [DW-1:0]     wr_data;
    logic              frame_ready;

    always #5 clk = ~clk;

    multi_ch_dual_buffer #(
        .DATA_WIDTH (DW),
        .ADC_WIDTH  (AWD),
        .CHANNELS   (CH),
        .BUF_SIZE   (BS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .addr_en        (addr_en),
        .rd_en          (rd_en),
        .wr_en          (wr_en),
        .adc_clk        (adc_clk),
        .sync_adc_data  (sync_adc_data),
        .stable         (stable),
        .sync_signal_in (sync_signal_in),
        .rd_data        (rd_data),
        .wr_data        (wr_data),
        .frame_ready    (frame_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: RAM image per half/channel, the half being filled,
    // and progress through the current frame.
    logic [AWD-1:0] model_mem [2][CH][BS];
    int             model_wbuf = 0;
    int             cap_idx = 0;
    int             decim_phase = 0;
    logic [AWD-1:0] ramp = 12'h000;
    logic [DW-1:0]  rdv;

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk); en = 1'b1; addr_en = 1'b1; rd_data = a;
        @(negedge clk); addr_en = 1'b0; rd_en = 1'b1; rd_data = d;
        @(negedge clk); rd_en = 1'b0; en = 1'b0; rd_data = '0;
        $display("bus write addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk); en = 1'b1; addr_en = 1'b1; rd_data = a;
        @(negedge clk); addr_en = 1'b0; rd_data = '0;
        @(negedge clk); wr_en = 1'b1;
        @(negedge clk); wr_en = 1'b0; en = 1'b0;
        d = wr_data;
        $display("bus read  addr=%h data=%h", a, d);
    endtask

    task automatic trig_edge(input logic level);
        @(negedge clk); sync_signal_in = level;
        repeat (6) @(negedge clk);
    endtask

    task automatic new_frame();
        cap_idx = 0;
        decim_phase = 0;
    endtask

    task automatic swap_model();
        model_wbuf = 1 - model_wbuf;
    endtask

    // Each pulse: ch0 carries a running ramp, ch1 a constant or random value.
    task automatic adc_pulses(input int n, input bit capture, input int decim, input bit ch1_rand);
        logic [AWD-1:0] v0, v1;
        for (int j = 0; j < n; j++) begin
            v0 = ramp;
            v1 = ch1_rand ? AWD'($urandom) : 12'hABC;
            @(negedge clk); sync_adc_data = {v1, v0}; adc_clk = 1'b1;
            @(negedge clk); adc_clk = 1'b0;
            if (capture && cap_idx < BS) begin
                if (decim_phase == 0) begin
                    model_mem[model_wbuf][0][cap_idx] = v0;
                    model_mem[model_wbuf][1][cap_idx] = v1;
                    cap_idx++;
                end
                decim_phase = (decim_phase == decim) ? 0 : decim_phase + 1;
            end
            ramp = ramp + 12'd1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_data !== 16'hFFFF) begin errors++; $display("FAIL reset_wr_data got=%h exp=ffff", wr_data); end
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready got=%b exp=0", frame_ready); end
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0000) begin errors++; $display("FAIL reset_status got=%h exp=0000", rdv); end
        // Strobes with en low must not reach the registers.
        @(negedge clk); addr_en = 1'b1; rd_data = 16'h4001;
        @(negedge clk); addr_en = 1'b0; rd_en = 1'b1; rd_data = 16'h0003;
        @(negedge clk); rd_en = 1'b0; rd_data = '0;
        bus_read(16'h4001, rdv);
        checks++;
        if (rdv !== 16'h0000) begin errors++; $display("FAIL en_gating_ctrl got=%h exp=0000", rdv); end
        bus_read(16'h5000, rdv);
        checks++;
        if (rdv !== 16'hFFFF) begin errors++; $display("FAIL unmapped_read got=%h exp=ffff", rdv); end
        bus_read(16'h4002, rdv);
        checks++;
`ifdef DUAL_BUF_DECIM_EN
        if (rdv !== 16'h0000) begin errors++; $display("FAIL decim_reset got=%h exp=0000", rdv); end
`else
        if (rdv !== 16'hFFFF) begin errors++; $display("FAIL decim_absent got=%h exp=ffff", rdv); end
`endif
    endtask

    task automatic test_basic_frame();
        trig_edge(1'b1);
        new_frame();
        adc_pulses(BS, 1'b1, 0, 1'b0);
        swap_model();
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL basic_frame_ready got=%b exp=1", frame_ready); end
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0001) begin errors++; $display("FAIL basic_status got=%h exp=0001", rdv); end
        bus_read(16'h0005, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1-model_wbuf][0][5]}) begin
            errors++; $display("FAIL basic_ch0_idx5 got=%h exp=%h", rdv, {4'h0, model_mem[1-model_wbuf][0][5]});
        end
        bus_read(16'h0405, rdv);
        checks++;
        if (rdv !== 16'h0ABC) begin errors++; $display("FAIL basic_ch1_idx5 got=%h exp=0abc", rdv); end
        bus_read(16'h0000, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1-model_wbuf][0][0]}) begin
            errors++; $display("FAIL basic_ch0_first got=%h exp=%h", rdv, {4'h0, model_mem[1-model_wbuf][0][0]});
        end
        bus_read(16'h03FF, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1-model_wbuf][0][BS-1]}) begin
            errors++; $display("FAIL basic_ch0_last got=%h exp=%h", rdv, {4'h0, model_mem[1-model_wbuf][0][BS-1]});
        end
    endtask

    task automatic test_overflow_reg_read();
        bus_write(16'h4000, 16'h0001);
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0000) begin errors++; $display("FAIL ovf_ack_status got=%h exp=0000", rdv); end
        trig_edge(1'b0);
        trig_edge(1'b1);
        adc_pulses(20, 1'b0, 0, 1'b0);
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0002) begin errors++; $display("FAIL ovf_set_status got=%h exp=0002", rdv); end
        bus_write(16'h4000, 16'h0002);
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0000) begin errors++; $display("FAIL ovf_clear_status got=%h exp=0000", rdv); end
        trig_edge(1'b0);
        trig_edge(1'b1);
        new_frame();
        adc_pulses(BS, 1'b1, 0, 1'b1);
        swap_model();
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0001) begin errors++; $display("FAIL ovf_next_frame_status got=%h exp=0001", rdv); end
        for (int k = 0; k < 6; k++) begin
            int c, i;
            c = $urandom_range(0, CH-1);
            i = $urandom_range(0, BS-1);
            bus_read(16'(c*BS + i), rdv);
            checks++;
            if (rdv !== {4'h0, model_mem[1-model_wbuf][c][i]}) begin
                errors++; $display("FAIL ovf_frame_data ch=%0d idx=%0d got=%h exp=%h", c, i, rdv, {4'h0, model_mem[1-model_wbuf][c][i]});
            end
        end
    endtask

    task automatic test_switch_stall();
        trig_edge(1'b0);
        trig_edge(1'b1);
        new_frame();
        adc_pulses(100, 1'b1, 0, 1'b1);
        bus_write(16'h4000, 16'h0001);
        adc_pulses(BS-100, 1'b1, 0, 1'b1);
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL stall_frame_ready got=%b exp=0", frame_ready); end
        // No swap yet: the previous frame must still be visible.
        for (int k = 0; k < 4; k++) begin
            int c, i;
            c = $urandom_range(0, CH-1);
            i = $urandom_range(0, BS-1);
            bus_read(16'(c*BS + i), rdv);
            checks++;
            if (rdv !== {4'h0, model_mem[1-model_wbuf][c][i]}) begin
                errors++; $display("FAIL stall_old_data ch=%0d idx=%0d got=%h exp=%h", c, i, rdv, {4'h0, model_mem[1-model_wbuf][c][i]});
            end
        end
        trig_edge(1'b0);
        trig_edge(1'b1);
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0002) begin errors++; $display("FAIL stall_overflow got=%h exp=0002", rdv); end
        bus_write(16'h4000, 16'h0002);
        repeat (4) @(negedge clk);
        swap_model();
        bus_read(16'h4000, rdv);
        checks++;
        if (rdv !== 16'h0001) begin errors++; $display("FAIL stall_release_status got=%h exp=0001", rdv); end
        for (int k = 0; k < 4; k++) begin
            int c, i;
            c = $urandom_range(0, CH-1);
            i = $urandom_range(0, BS-1);
            bus_read(16'(c*BS + i), rdv);
            checks++;
            if (rdv !== {4'h0, model_mem[1-model_wbuf][c][i]}) begin
                errors++; $display("FAIL stall_new_data ch=%0d idx=%0d got=%h exp=%h", c, i, rdv, {4'h0, model_mem[1-model_wbuf][c][i]});
            end
        end
    endtask

    task automatic test_trig_falling();
        bus_write(16'h4000, 16'h0001);
        bus_write(16'h4000, 16'h0000);
        trig_edge(1'b0);
        bus_write(16'h4001, 16'h0001);
        bus_read(16'h4001, rdv);
        checks++;
        if (rdv !== 16'h0001) begin errors++; $display("FAIL fall_ctrl_readback got=%h exp=0001", rdv); end
        trig_edge(1'b1);
        adc_pulses(BS, 1'b0, 0, 1'b1);
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL fall_rise_ignored got=%b exp=0", frame_ready); end
        trig_edge(1'b0);
        new_frame();
        adc_pulses(BS, 1'b1, 0, 1'b1);
        swap_model();
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL fall_capture_ready got=%b exp=1", frame_ready); end
        for (int k = 0; k < 4; k++) begin
            int c, i;
            c = $urandom_range(0, CH-1);
            i = $urandom_range(0, BS-1);
            bus_read(16'(c*BS + i), rdv);
            checks++;
            if (rdv !== {4'h0, model_mem[1-model_wbuf][c][i]}) begin
                errors++; $display("FAIL fall_data ch=%0d idx=%0d got=%h exp=%h", c, i, rdv, {4'h0, model_mem[1-model_wbuf][c][i]});
            end
        end
    endtask

    task automatic test_stable_drop();
        bus_write(16'h4000, 16'h0001);
        bus_write(16'h4000, 16'h0000);
        bus_write(16'h4001, 16'h0002);
        trig_edge(1'b1);
        new_frame();
        adc_pulses(500, 1'b1, 0, 1'b1);
        @(negedge clk); stable = 1'b0;
        repeat (4) @(negedge clk);
        stable = 1'b1;
        repeat (4) @(negedge clk);
        adc_pulses(600, 1'b0, 0, 1'b1);
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL drop_frame_ready got=%b exp=0", frame_ready); end
        bus_read(16'h0005, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1-model_wbuf][0][5]}) begin
            errors++; $display("FAIL drop_read_half got=%h exp=%h", rdv, {4'h0, model_mem[1-model_wbuf][0][5]});
        end
        trig_edge(1'b0);
        new_frame();
        adc_pulses(BS, 1'b1, 0, 1'b1);
        swap_model();
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL drop_recapture_ready got=%b exp=1", frame_ready); end
        for (int k = 0; k < 4; k++) begin
            int c, i;
            c = $urandom_range(0, CH-1);
            i = $urandom_range(0, BS-1);
            bus_read(16'(c*BS + i), rdv);
            checks++;
            if (rdv !== {4'h0, model_mem[1-model_wbuf][c][i]}) begin
                errors++; $display("FAIL drop_data ch=%0d idx=%0d got=%h exp=%h", c, i, rdv, {4'h0, model_mem[1-model_wbuf][c][i]});
            end
        end
    endtask

`ifdef DUAL_BUF_DECIM_EN
    task automatic test_decim();
        bus_write(16'h4000, 16'h0001);
        bus_write(16'h4000, 16'h0000);
        bus_write(16'h4001, 16'h0000);
        bus_write(16'h4002, 16'h0003);
        bus_read(16'h4002, rdv);
        checks++;
        if (rdv !== 16'h0003) begin errors++; $display("FAIL decim_readback got=%h exp=0003", rdv); end
        trig_edge(1'b1);
        new_frame();
        adc_pulses(4*BS, 1'b1, 3, 1'b0);
        swap_model();
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL decim_ready got=%b exp=1", frame_ready); end
        for (int k = 0; k < 6; k++) begin
            int i;
            i = $urandom_range(0, BS-1);
            bus_read(16'(i), rdv);
            checks++;
            if (rdv !== {4'h0, model_mem[1-model_wbuf][0][i]}) begin
                errors++; $display("FAIL decim_data idx=%0d got=%h exp=%h", i, rdv, {4'h0, model_mem[1-model_wbuf][0][i]});
            end
        end
        bus_write(16'h4002, 16'h0000);
    endtask
`endif

    task automatic test_reset_mid_frame();
        bus_write(16'h4001, 16'h0002);
        trig_edge(!sync_signal_in);
        new_frame();
        adc_pulses(300, 1'b1, 0, 1'b1);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_wbuf = 0;
        @(negedge clk);
        checks++;
        if (wr_data !== 16'hFFFF) begin errors++; $display("FAIL midrst_wr_data got=%h exp=ffff", wr_data); end
        checks++;
        if (frame_ready !== 1'b0) begin errors++; $display("FAIL midrst_frame_ready got=%b exp=0", frame_ready); end
        bus_read(16'h4001, rdv);
        checks++;
        if (rdv !== 16'h0000) begin errors++; $display("FAIL midrst_ctrl got=%h exp=0000", rdv); end
        // RAM survives reset; half 1 is the read half again.
        bus_read(16'h0005, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1][0][5]}) begin
            errors++; $display("FAIL midrst_ram_kept got=%h exp=%h", rdv, {4'h0, model_mem[1][0][5]});
        end
        if (sync_signal_in) trig_edge(1'b0);
        trig_edge(1'b1);
        new_frame();
        adc_pulses(BS, 1'b1, 0, 1'b1);
        swap_model();
        checks++;
        if (frame_ready !== 1'b1) begin errors++; $display("FAIL midrst_recapture got=%b exp=1", frame_ready); end
        bus_read(16'h0000, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1-model_wbuf][0][0]}) begin
            errors++; $display("FAIL midrst_idx0 got=%h exp=%h", rdv, {4'h0, model_mem[1-model_wbuf][0][0]});
        end
        bus_read(16'h07FF, rdv);
        checks++;
        if (rdv !== {4'h0, model_mem[1-model_wbuf][1][BS-1]}) begin
            errors++; $display("FAIL midrst_ch1_last got=%h exp=%h", rdv, {4'h0, model_mem[1-model_wbuf][1][BS-1]});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow_reg_read();
        test_switch_stall();
        test_trig_falling();
        test_stable_drop();
`ifdef DUAL_BUF_DECIM_EN
        test_decim();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
